cq_viola_led_pwm: RTL and testbench
===================================

CQ_VIOLA_LED_PWM -- requirements
Module: cq_viola_led_pwm

Interface
- REQ-001: clk  input  1  system clock; all state updates on rising edge.
- REQ-002: reset_n  input  1  reset; asynchronous assert, active-low, released synchronously to clk by the system.
- REQ-003: address  input  2  Avalon-MM slave word address.
- REQ-004: chipselect  input  1  slave select.
- REQ-005: write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
- REQ-006: writedata  input  32  write data.
- REQ-007: readdata  output  32  read data; combinational from address, zero wait states.
- REQ-008: led_in  input  1  LED request bit from the LED PIO's out_port.
- REQ-009: led_out  output  1  PWM-modulated LED drive, registered.

Function
- REQ-010: The register map SHALL be: 0 CTRL (bit0 EN, bit1 BREATHE), 1 DUTY[7:0], 2 PRESCALE[15:0], 3 STATUS (read-only, LEVEL[7:0] in bits 7:0, DIR in bit 8); unused bits read 0 and are ignored on write.
- REQ-011: A write to address 3 SHALL have no effect.
- REQ-012: Prescaler counter SHALL count 0..PRESCALE and emit a one-cycle tick when it equals PRESCALE, then wrap to 0; PRESCALE=0 gives a tick every clk.
- REQ-013: A write to PRESCALE SHALL clear the prescaler counter in the same cycle.
- REQ-014: The 8-bit PWM counter SHALL increment on each tick and wrap 255->0; the cycle in which it wraps on a tick is the period boundary.
- REQ-015: led_out SHALL be registered as led_in AND EN AND (pwm_cnt < LEVEL), giving 1 clk latency from any input change.
- REQ-016: LEVEL=0 SHALL give constant 0; LEVEL=255 SHALL give 255 of every 256 PWM steps high.
- REQ-017: In static mode (BREATHE=0), LEVEL SHALL load DUTY only at the period boundary; a DUTY write never alters the current period.
- REQ-018: EN=0 SHALL force led_out=0 next clk while the counters keep running.
- REQ-019: A write coinciding with a period boundary SHALL be used by the boundary update in that same cycle, i.e. DUTY as seen at the boundary is the newly written value.

Reset
- REQ-020: On reset_n=0: CTRL, DUTY, PRESCALE, prescaler, pwm_cnt, LEVEL, DIR=0 (up) and led_out=0, immediately and asynchronously.
- REQ-021: Reset asserted mid-period or mid-breathe SHALL discard all progress; after release operation restarts from pwm_cnt=0, LEVEL=0.

Configuration
- REQ-022: Macro CQ_VIOLA_LED_PWM_BREATHE_EN SHALL compile in the breathe engine.
- REQ-023: With the macro and BREATHE=1, each period boundary SHALL update LEVEL: when DIR=up, LEVEL<DUTY gives LEVEL+1, else LEVEL=DUTY and DIR=down; when DIR=down, LEVEL>0 gives LEVEL-1, else DIR=up.
- REQ-024: Clearing BREATHE SHALL return to the REQ-017 behaviour at the next boundary, with DIR reset to up.
- REQ-025: Without the macro, CTRL bit1 SHALL read 0 and be ignored, STATUS DIR SHALL read 0, and no breathe logic SHALL be synthesised.

Verification
- REQ-026: Reset, then write EN=1, DUTY=64, PRESCALE=0, hold led_in=1 -> after the first boundary led_out is high 64 clk then low 192 clk, repeating.
- REQ-027: Change DUTY 64->200 mid-period -> the current period stays at 64 high; the next period is 200 high.
- REQ-028: PRESCALE=3 -> pwm_cnt advances every 4 clk; a PRESCALE write clears the prescaler (tick 4 clk after the write).
- REQ-029: DUTY=255 -> 255 high / 1 low per period; DUTY=0 -> led_out stays 0; led_in=0 or EN=0 -> led_out=0 one clk later.
- REQ-030: (macro on) DUTY=3, BREATHE=1 -> STATUS LEVEL sequence per boundary is 1,2,3,3(DIR down),2,1,0,0(DIR up),1.
- REQ-031: Assert reset_n mid-period with LEVEL=2 and DIR=down -> led_out and all registers are 0 immediately, and readdata at address 3 = 0.

Source files
------------

// File: rtl/cq_viola_led_pwm.sv
// Avalon-MM controlled LED PWM: prescaled 8-bit PWM gated by led_in and EN.
// Define CQ_VIOLA_LED_PWM_BREATHE_EN to compile in the breathe (ramp up/down) engine.
module cq_viola_led_pwm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        led_in,
  output logic        led_out
);

  logic        wr;
  logic        wr_ctrl;
  logic        wr_duty;
  logic        wr_prescale;

  logic        en;
  logic [7:0]  duty;
  logic [15:0] prescale;
  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  level;
  logic        breathe;
  logic        dir;

  logic        tick;
  logic        boundary;
  logic [7:0]  duty_nx;
  logic [7:0]  level_nx;

  assign wr          = chipselect & ~write_n;
  assign wr_ctrl     = wr && (address == 2'd0);
  assign wr_duty     = wr && (address == 2'd1);
  assign wr_prescale = wr && (address == 2'd2);

  // A PRESCALE write restarts the prescaler, so the stale compare must not tick.
  assign tick     = (pre_cnt == prescale) && !wr_prescale;
  assign boundary = tick && (pwm_cnt == 8'hFF);

  // The boundary update sees a DUTY write landing in the same cycle.
  assign duty_nx  = wr_duty ? writedata[7:0] : duty;

`ifdef CQ_VIOLA_LED_PWM_BREATHE_EN
  logic breathe_nx;
  logic dir_nx;
  logic unused_wdata;

  assign breathe_nx   = wr_ctrl ? writedata[1] : breathe;
  assign unused_wdata = ^writedata[31:16];

  always_comb begin
    level_nx = duty_nx;
    dir_nx   = 1'b0;
    if (breathe_nx) begin
      if (!dir) begin
        if (level < duty_nx) begin
          level_nx = level + 8'd1;
        end else begin
          level_nx = duty_nx;
          dir_nx   = 1'b1;
        end
      end else begin
        if (level != 8'd0) begin
          level_nx = level - 8'd1;
          dir_nx   = 1'b1;
        end else begin
          level_nx = level;
          dir_nx   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      breathe <= 1'b0;
      dir     <= 1'b0;
    end else begin
      if (wr_ctrl)
        breathe <= writedata[1];
      if (boundary)
        dir <= dir_nx;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^{writedata[31:16], writedata[1]};
  assign breathe      = 1'b0;
  assign dir          = 1'b0;
  assign level_nx     = duty_nx;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en       <= 1'b0;
      duty     <= 8'd0;
      prescale <= 16'd0;
      pre_cnt  <= 16'd0;
      pwm_cnt  <= 8'd0;
      level    <= 8'd0;
      led_out  <= 1'b0;
    end else begin
      if (wr_ctrl)
        en <= writedata[0];
      if (wr_duty)
        duty <= writedata[7:0];
      if (wr_prescale)
        prescale <= writedata[15:0];

      if (wr_prescale || tick)
        pre_cnt <= 16'd0;
      else
        pre_cnt <= pre_cnt + 16'd1;

      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (boundary)
        level <= level_nx;

      led_out <= led_in & en & (pwm_cnt < level);
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata[1:0]  = {breathe, en};
      2'd1:    readdata[7:0]  = duty;
      2'd2:    readdata[15:0] = prescale;
      default: readdata[8:0]  = {dir, level};
    endcase
  end

endmodule

// File: tb/tb_cq_viola_led_pwm.sv
// Directed bench for cq_viola_led_pwm: register map, PWM timing, gating, prescaler and reset.
module tb_cq_viola_led_pwm;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        led_in;
  logic        led_out;

  int n_checks;
  int n_errors;

  cq_viola_led_pwm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led_in     (led_in),
    .led_out    (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All bench actions happen 1 time unit after a rising edge.
  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input logic v, input int limit, output bit ok);
    int n = 0;
    while (led_out !== v && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (led_out === v);
  endtask

  task automatic run_len(input logic v, input int limit, output int n);
    n = 0;
    while (led_out === v && n < limit) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (led_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_led_out: got %b want 0", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_reg%0d: got %h want 00000000", a, d);
      end
    end
    do_reset();
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic [31:0] exp_ctrl;
`ifdef CQ_VIOLA_LED_PWM_BREATHE_EN
    exp_ctrl = 32'h3;
`else
    exp_ctrl = 32'h1;
`endif
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'h0000_ABCD);
    do_write(2'd2, 32'hDEAD_BEEF);
    do_write(2'd3, 32'hFFFF_FFFF);
    read_reg(2'd0, d);
    n_checks++;
    if (d !== exp_ctrl) begin
      n_errors++;
      $display("FAIL regs_ctrl: got %h want %h", d, exp_ctrl);
    end
    read_reg(2'd1, d);
    n_checks++;
    if (d !== 32'h0000_00CD) begin
      n_errors++;
      $display("FAIL regs_duty: got %h want 000000cd", d);
    end
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'h0000_BEEF) begin
      n_errors++;
      $display("FAIL regs_prescale: got %h want 0000beef", d);
    end
    read_reg(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_errors++;
      $display("FAIL regs_status_ro: got %h want 00000000", d);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    do_reset();
    led_in = 1'b1;
    do_write(2'd0, 32'h1);
    do_write(2'd1, 32'd64);
    do_write(2'd2, 32'd0);
    wait_for(1'b1, 600, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_rise: led_out never rose within 600 clk");
    end
    run_len(1'b1, 400, n);
    n_checks++;
    if (n != 64) begin
      n_errors++;
      $display("FAIL basic_high: got %0d clk want 64", n);
    end
    run_len(1'b0, 400, n);
    n_checks++;
    if (n != 192) begin
      n_errors++;
      $display("FAIL basic_low: got %0d clk want 192", n);
    end
    run_len(1'b1, 400, n);
    n_checks++;
    if (n != 64) begin
      n_errors++;
      $display("FAIL basic_high2: got %0d clk want 64", n);
    end
  endtask

  task automatic test_duty_change();
    bit ok;
    int n;
    wait_for(1'b1, 400, ok);
    n = 0;
    while (led_out === 1'b1 && n < 400) begin
      n++;
      if (n == 10) begin
        address    = 2'd1;
        writedata  = 32'd200;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
    end
    n_checks++;
    if (n != 64) begin
      n_errors++;
      $display("FAIL duty_change_cur_high: got %0d clk want 64", n);
    end
    run_len(1'b0, 400, n);
    n_checks++;
    if (n != 192) begin
      n_errors++;
      $display("FAIL duty_change_cur_low: got %0d clk want 192", n);
    end
    run_len(1'b1, 400, n);
    n_checks++;
    if (n != 200) begin
      n_errors++;
      $display("FAIL duty_change_next_high: got %0d clk want 200", n);
    end
    run_len(1'b0, 400, n);
    n_checks++;
    if (n != 56) begin
      n_errors++;
      $display("FAIL duty_change_next_low: got %0d clk want 56", n);
    end
  endtask

  task automatic test_duty_extremes();
    bit ok;
    int n;
    int highs;
    do_write(2'd1, 32'd255);
    wait_for(1'b0, 400, ok);
    wait_for(1'b1, 400, ok);
    run_len(1'b1, 400, n);
    n_checks++;
    if (n != 255) begin
      n_errors++;
      $display("FAIL duty255_high: got %0d clk want 255", n);
    end
    run_len(1'b0, 400, n);
    n_checks++;
    if (n != 1) begin
      n_errors++;
      $display("FAIL duty255_low: got %0d clk want 1", n);
    end
    do_write(2'd1, 32'd0);
    repeat (600) @(posedge clk);
    #1;
    highs = 0;
    for (int i = 0; i < 520; i++) begin
      if (led_out !== 1'b0)
        highs++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (highs != 0) begin
      n_errors++;
      $display("FAIL duty0_high_count: got %0d clk high want 0", highs);
    end
  endtask

  task automatic test_gating();
    bit ok;
    do_write(2'd1, 32'd64);
    wait_for(1'b1, 600, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL gating_rise: led_out never rose within 600 clk");
    end
    led_in = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (led_out !== 1'b0) begin
      n_errors++;
      $display("FAIL gating_led_in_low: got %b want 0", led_out);
    end
    led_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (led_out !== 1'b1) begin
      n_errors++;
      $display("FAIL gating_led_in_restore: got %b want 1", led_out);
    end
    do_write(2'd0, 32'h0);
    @(posedge clk);
    #1;
    n_checks++;
    if (led_out !== 1'b0) begin
      n_errors++;
      $display("FAIL gating_en_low: got %b want 0", led_out);
    end
    do_write(2'd0, 32'h1);
    @(posedge clk);
    #1;
    n_checks++;
    if (led_out !== 1'b1) begin
      n_errors++;
      $display("FAIL gating_en_restore: got %b want 1", led_out);
    end
  endtask

  task automatic test_prescale();
    bit ok;
    int n;
    do_write(2'd2, 32'd3);
    do_write(2'd1, 32'd2);
    wait_for(1'b0, 3000, ok);
    wait_for(1'b1, 3000, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL prescale_rise: led_out never rose within 3000 clk");
    end
    run_len(1'b1, 2000, n);
    n_checks++;
    if (n != 8) begin
      n_errors++;
      $display("FAIL prescale_high: got %0d clk want 8", n);
    end
    run_len(1'b0, 2000, n);
    n_checks++;
    if (n != 1016) begin
      n_errors++;
      $display("FAIL prescale_low: got %0d clk want 1016", n);
    end
    // Rewriting PRESCALE on the second high clk restarts the prescaler, stretching the step.
    do_write(2'd2, 32'd3);
    run_len(1'b1, 2000, n);
    n_checks++;
    if (n + 1 != 10) begin
      n_errors++;
      $display("FAIL prescale_clear_high: got %0d clk want 10", n + 1);
    end
    do_write(2'd2, 32'd0);
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int n;
    logic [31:0] d;
    do_write(2'd1, 32'd64);
    wait_for(1'b1, 3000, ok);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (led_out !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_reset_led: got %b want 0", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_errors++;
        $display("FAIL midrun_reset_reg%0d: got %h want 00000000", a, d);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_write(2'd0, 32'h1);
    do_write(2'd1, 32'd64);
    n = 0;
    while (led_out !== 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (n != 255) begin
      n_errors++;
      $display("FAIL midrun_restart_latency: got %0d clk want 255", n);
    end
  endtask

`ifdef CQ_VIOLA_LED_PWM_BREATHE_EN
  task automatic test_breathe();
    logic [31:0] d;
    logic [31:0] exp_seq [0:8];
    int n;
    exp_seq = '{32'h001, 32'h002, 32'h003, 32'h103, 32'h102,
                32'h101, 32'h100, 32'h000, 32'h001};
    do_reset();
    do_write(2'd1, 32'd3);
    do_write(2'd0, 32'h3);
    n = 0;
    read_reg(2'd3, d);
    while (d[7:0] != 8'd1 && n < 600) begin
      @(posedge clk);
      #1;
      read_reg(2'd3, d);
      n++;
    end
    n_checks++;
    if (d !== exp_seq[0]) begin
      n_errors++;
      $display("FAIL breathe_step0: got %h want %h", d, exp_seq[0]);
    end
    for (int i = 1; i < 9; i++) begin
      repeat (256) @(posedge clk);
      #1;
      read_reg(2'd3, d);
      n_checks++;
      if (d !== exp_seq[i]) begin
        n_errors++;
        $display("FAIL breathe_step%0d: got %h want %h", i, d, exp_seq[i]);
      end
    end
    repeat (4 * 256 + 100) @(posedge clk);
    #1;
    read_reg(2'd3, d);
    n_checks++;
    if (d !== 32'h102) begin
      n_errors++;
      $display("FAIL breathe_pre_reset: got %h want 00000102", d);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (led_out !== 1'b0) begin
      n_errors++;
      $display("FAIL breathe_reset_led: got %b want 0", led_out);
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(a[1:0], d);
      n_checks++;
      if (d !== 32'd0) begin
        n_errors++;
        $display("FAIL breathe_reset_reg%0d: got %h want 00000000", a, d);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset_n    = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    led_in     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_regs();
    test_basic();
    test_duty_change();
    test_duty_extremes();
    test_gating();
    test_prescale();
    test_reset_midrun();
`ifdef CQ_VIOLA_LED_PWM_BREATHE_EN
    test_breathe();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
